// File: rtl/hazard_pkg.sv
// Shared constants and shadow-pipeline entry types for the hazard
// scoreboard: forwarding codes, Tuse sentinel, MDU FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_E  = 2'd3;

  // Tuse value meaning "operand not read"; never below any Tnew.
  localparam int unsigned TUSE_NONE = 3;

  typedef enum logic [1:0] {
    MDU_IDLE  = 2'd0,
    MDU_PEND  = 2'd1,
    MDU_COUNT = 2'd2
  } mdu_state_e;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       we;
    logic       md_start;
    logic       md_div;
  } e_ent_t;

  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] dst;
    logic       we;
  } m_ent_t;

  typedef struct packed {
    logic [4:0] dst;
    logic       we;
  } w_ent_t;

  // A stage supplies a source when it writes that nonzero register.
  function automatic logic hit(
    input logic [4:0] src,
    input logic [4:0] dst,
    input logic       we
  );
    return (src != 5'd0) && (src == dst) && we;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_mdu.sv
// MDU busy tracker: IDLE -> PEND -> COUNT -> IDLE.
// Ports: clk_i, reset_i, e_start_i, e_div_i, flush_i -> busy_o.
module mdu_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic e_start_i,
  input  logic e_div_i,
  input  logic flush_i,
  output logic busy_o
);

  localparam int MAXC =
    (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  mdu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          div_q, div_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    unique case (state_q)
      MDU_IDLE: begin
        // A start still in E is dropped when flushed.
        if (e_start_i && !flush_i) begin
          state_d = MDU_PEND;
          div_d   = e_div_i;
        end
      end
      MDU_PEND: begin
        state_d = MDU_COUNT;
        cnt_d   = div_q ? CW'(DIV_CYCLES - 1)
                        : CW'(MULT_CYCLES - 1);
      end
      MDU_COUNT: begin
        cnt_d = cnt_q - CW'(1);
        // Leave as the count reaches zero.
        if (cnt_q <= CW'(1)) begin
          state_d = MDU_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
    end
  end

  assign busy_o = (state_q != MDU_IDLE) | e_start_i;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: shadow E/M/W pipeline, stall/forward/flush control.
// Ports: D-stage operand info and flush in; enables, clears, fwd selects,
// md_busy and stall_cnt out.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int TNEW_W      = 2,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        rs_d,
  input  logic [4:0]        rt_d,
  input  logic [4:0]        dst_d,
  input  logic              we_d,
  input  logic [TNEW_W-1:0] tnew_d,
  input  logic [TNEW_W-1:0] tuse_rs_d,
  input  logic [TNEW_W-1:0] tuse_rt_d,
  input  logic              md_start_d,
  input  logic              md_div_d,
  input  logic              md_use_d,
  input  logic              flush,
  output logic              en_pc,
  output logic              en_d,
  output logic              clr_e,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic              fwd_rt_m,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  e_ent_t            e_q, e_d;
  m_ent_t            m_q, m_d;
  w_ent_t            w_q, w_d;
  logic [TNEW_W-1:0] e_tnew_q, e_tnew_d;
  logic [TNEW_W-1:0] m_tnew_q, m_tnew_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic e_rs, e_rt, m_rs, m_rt, w_rs, w_rt;
  logic xm_rs, xm_rt, xw_rs, xw_rt;
  logic e_tz, m_tz;
  logic stall_rs, stall_rt, stall;

  function automatic logic [TNEW_W-1:0] tdec(
    input logic [TNEW_W-1:0] t
  );
    return (t == '0) ? t : t - TNEW_W'(1);
  endfunction

  // Nearest match decides; a not-yet-ready result reads RF (stall covers).
  function automatic logic [1:0] fwd_sel(
    input logic he, input logic ze,
    input logic hm, input logic zm,
    input logic hw
  );
    if (he)      return ze ? FWD_E : FWD_RF;
    else if (hm) return zm ? FWD_M : FWD_RF;
    else if (hw) return FWD_W;
    else         return FWD_RF;
  endfunction

  assign e_rs = hit(rs_d, e_q.dst, e_q.we);
  assign e_rt = hit(rt_d, e_q.dst, e_q.we);
  assign m_rs = hit(rs_d, m_q.dst, m_q.we);
  assign m_rt = hit(rt_d, m_q.dst, m_q.we);
  assign w_rs = hit(rs_d, w_q.dst, w_q.we);
  assign w_rt = hit(rt_d, w_q.dst, w_q.we);

  assign xm_rs = hit(e_q.rs, m_q.dst, m_q.we);
  assign xm_rt = hit(e_q.rt, m_q.dst, m_q.we);
  assign xw_rs = hit(e_q.rs, w_q.dst, w_q.we);
  assign xw_rt = hit(e_q.rt, w_q.dst, w_q.we);

  assign e_tz = (e_tnew_q == '0);
  assign m_tz = (m_tnew_q == '0);

  assign stall_rs = (e_rs && (tuse_rs_d < e_tnew_q))
                 || (m_rs && (tuse_rs_d < m_tnew_q));
  assign stall_rt = (e_rt && (tuse_rt_d < e_tnew_q))
                 || (m_rt && (tuse_rt_d < m_tnew_q));
  assign stall    = stall_rs | stall_rt | (md_use_d & md_busy);

  assign en_pc   = ~stall | flush;
  assign en_d    = ~stall;
  assign clr_e   = stall;
  assign flush_d = flush;
  assign flush_e = flush;
  assign flush_m = flush;

  assign fwd_rs_d = fwd_sel(e_rs, e_tz, m_rs, m_tz, w_rs);
  assign fwd_rt_d = fwd_sel(e_rt, e_tz, m_rt, m_tz, w_rt);
  assign fwd_rs_e = fwd_sel(1'b0, 1'b0, xm_rs, m_tz, xw_rs);
  assign fwd_rt_e = fwd_sel(1'b0, 1'b0, xm_rt, m_tz, xw_rt);
  assign fwd_rt_m = hit(m_q.rt, w_q.dst, w_q.we);

  assign stall_cnt = cnt_q;

  always_comb begin
    e_d      = '0;
    e_tnew_d = '0;
    m_d      = '0;
    m_tnew_d = '0;
    w_d      = '{dst: m_q.dst, we: m_q.we};
    cnt_d    = cnt_q;
    // Flush bubbles E and M and overrides any stall bubble.
    if (!flush) begin
      m_d      = '{rt: e_q.rt, dst: e_q.dst, we: e_q.we};
      m_tnew_d = tdec(e_tnew_q);
      if (!stall) begin
        e_d = '{rs: rs_d, rt: rt_d, dst: dst_d, we: we_d,
                md_start: md_start_d, md_div: md_div_d};
        e_tnew_d = tnew_d;
      end else if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q      <= '0;
      e_tnew_q <= '0;
      m_q      <= '0;
      m_tnew_q <= '0;
      w_q      <= '0;
      cnt_q    <= '0;
    end else begin
      e_q      <= e_d;
      e_tnew_q <= e_tnew_d;
      m_q      <= m_d;
      m_tnew_q <= m_tnew_d;
      w_q      <= w_d;
      cnt_q    <= cnt_d;
    end
  end

  mdu_busy_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_mdu (
    .clk_i     (clk),
    .reset_i   (reset),
    .e_start_i (e_q.md_start),
    .e_div_i   (e_q.md_div),
    .flush_i   (flush),
    .busy_o    (md_busy)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: vector table plus
// MDU/flush/reset sequences.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam logic [1:0] TN = 2'(TUSE_NONE);

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_d, rt_d, dst_d;
  logic        we_d;
  logic [1:0]  tnew_d, tuse_rs_d, tuse_rt_d;
  logic        md_start_d, md_div_d, md_use_d, flush;
  logic        en_pc, en_d, clr_e;
  logic        flush_d, flush_e, flush_m;
  logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic        fwd_rt_m, md_busy;
  logic [31:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .dst_d(dst_d), .we_d(we_d),
    .tnew_d(tnew_d), .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
    .md_start_d(md_start_d), .md_div_d(md_div_d),
    .md_use_d(md_use_d), .flush(flush),
    .en_pc(en_pc), .en_d(en_d), .clr_e(clr_e),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
    .fwd_rt_m(fwd_rt_m), .md_busy(md_busy),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [4:0]  rs, rt, dst;
    logic        we;
    logic [1:0]  tnew, tur, tut;
    logic [15:0] exp;
    int          cnt;
  } vec_t;

  function automatic logic [15:0] pk(
    input logic ep, input logic ed, input logic ce, input logic fl,
    input logic [1:0] a, input logic [1:0] b,
    input logic [1:0] c, input logic [1:0] d,
    input logic fm, input logic bsy
  );
    return {ep, ed, ce, fl, fl, fl, a, b, c, d, fm, bsy};
  endfunction

  function automatic logic [15:0] obs();
    return {en_pc, en_d, clr_e, flush_d, flush_e, flush_m,
            fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e,
            fwd_rt_m, md_busy};
  endfunction

  function automatic vec_t mk(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] dst, input logic we,
    input logic [1:0] tnew, input logic [1:0] tur,
    input logic [1:0] tut,
    input logic [1:0] a, input logic [1:0] b,
    input logic [1:0] c, input logic [1:0] d,
    input logic fm, input logic st, input int cnt
  );
    vec_t v;
    v.rs = rs; v.rt = rt; v.dst = dst; v.we = we;
    v.tnew = tnew; v.tur = tur; v.tut = tut;
    v.exp = pk(~st, ~st, st, 1'b0, a, b, c, d, fm, 1'b0);
    v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] dst, input logic we,
    input logic [1:0] tnew, input logic [1:0] tur,
    input logic [1:0] tut, input logic mds, input logic mdd,
    input logic mdu, input logic fl
  );
    rs_d = rs; rt_d = rt; dst_d = dst; we_d = we;
    tnew_d = tnew; tuse_rs_d = tur; tuse_rt_d = tut;
    md_start_d = mds; md_div_d = mdd; md_use_d = mdu;
    flush = fl;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[13];
  int   n;
  logic [15:0] idle;

  initial begin
    idle = pk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // rs rt dst we tnew tur tut | frsd frtd frse frte frtm stall cnt
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 8, 1, 2, TN, TN, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(8, 0, 9, 1, 1, 0, TN, 0, 0, 0, 0, 0, 1, 0);
    tbl[3]  = mk(8, 0, 9, 1, 1, 0, TN, 0, 0, 0, 0, 0, 1, 1);
    tbl[4]  = mk(8, 0, 9, 1, 1, 0, TN, 1, 0, 0, 0, 0, 0, 2);
    tbl[5]  = mk(0, 0, 31, 1, 0, TN, TN, 0, 0, 0, 0, 0, 0, 2);
    tbl[6]  = mk(31, 9, 0, 0, 0, 0, 0, 3, 2, 0, 0, 0, 0, 2);
    tbl[7]  = mk(0, 0, 0, 0, 0, TN, TN, 0, 0, 2, 1, 0, 0, 2);
    tbl[8]  = mk(0, 0, 5, 1, 1, TN, TN, 0, 0, 0, 0, 0, 0, 2);
    tbl[9]  = mk(0, 5, 5, 1, 1, TN, TN, 0, 0, 0, 0, 0, 0, 2);
    tbl[10] = mk(5, 0, 0, 0, 0, 1, TN, 0, 0, 0, 2, 0, 0, 2);
    tbl[11] = mk(0, 0, 0, 0, 0, TN, TN, 0, 0, 2, 0, 1, 0, 2);
    tbl[12] = mk(0, 0, 0, 0, 0, TN, TN, 0, 0, 0, 0, 0, 0, 2);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nxt(); nxt();
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].rs, tbl[i].rt, tbl[i].dst, tbl[i].we,
            tbl[i].tnew, tbl[i].tur, tbl[i].tut, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("vec%0d outs", i), 32'(obs()), 32'(tbl[i].exp));
      chk($sformatf("vec%0d cnt", i), stall_cnt, tbl[i].cnt);
      nxt();
    end

    // div followed by a HI/LO reader
    drive(0, 0, 0, 0, 0, TN, TN, 1, 1, 1, 0);
    @(negedge clk);
    chk("div issue", 32'(obs()), 32'(idle));
    nxt();
    drive(0, 0, 10, 1, 1, TN, TN, 0, 0, 1, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!clr_e) break;
      if (i == 0) chk("div busy", 32'(md_busy), 1);
      n++;
      nxt();
    end
    chk("div stall len", n, 11);
    chk("div release", 32'(obs()), 32'(idle));
    chk("div cnt", stall_cnt, 13);
    nxt();

    // mult in E cancelled by flush, with a stall in the same cycle
    drive(0, 0, 0, 0, 0, TN, TN, 1, 0, 1, 0);
    nxt();
    drive(10, 0, 0, 0, 0, 0, TN, 0, 0, 1, 1);
    @(negedge clk);
    chk("flushE outs", 32'(obs()),
        32'(pk(1, 0, 1, 1, 2, 0, 0, 0, 0, 1)));
    nxt();
    drive(10, 0, 0, 0, 0, 0, TN, 0, 0, 0, 0);
    @(negedge clk);
    chk("flushE after", 32'(obs()),
        32'(pk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0)));
    chk("flushE cnt", stall_cnt, 13);
    nxt();
    drive(0, 0, 0, 0, 0, TN, TN, 0, 0, 0, 0);
    @(negedge clk);
    chk("flushE idle", 32'(md_busy), 0);
    nxt();

    // mult already counting survives a flush
    drive(0, 0, 0, 0, 0, TN, TN, 1, 0, 1, 0);
    nxt();
    drive(0, 0, 0, 0, 0, TN, TN, 0, 0, 0, 0);
    nxt(); nxt();
    drive(0, 0, 0, 0, 0, TN, TN, 0, 0, 0, 1);
    @(negedge clk);
    chk("flushC outs", 32'(obs()),
        32'(pk(1, 1, 0, 1, 0, 0, 0, 0, 0, 1)));
    nxt();
    drive(0, 0, 0, 0, 0, TN, TN, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!md_busy) break;
      n++;
      nxt();
    end
    chk("flushC busy tail", n, 3);
    nxt();

    // async reset mid-COUNT while a load-use stall is pending
    drive(0, 0, 0, 0, 0, TN, TN, 1, 1, 0, 0);
    nxt();
    drive(0, 0, 8, 1, 2, TN, TN, 0, 0, 0, 0);
    nxt();
    drive(8, 0, 0, 0, 0, 0, TN, 0, 0, 0, 0);
    nxt();
    @(negedge clk);
    chk("pre-reset outs", 32'(obs()),
        32'(pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1)));
    chk("pre-reset cnt", stall_cnt, 14);
    #1 reset = 1'b1;
    #1;
    chk("async reset outs", 32'(obs()), 32'(idle));
    chk("async reset cnt", stall_cnt, 0);
    nxt();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post-reset outs", 32'(obs()), 32'(idle));
    chk("post-reset cnt", stall_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
